// File: rtl/cnn_accel_pkg.sv
// Shared state encoding and buffer sizing for the CNN accelerator memory sequencers.
package cnn_accel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    READ,
    DRAIN,
    DONE
  } rd_state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/channel_skid_buf.sv
// Two-entry valid/ready buffer; the head entry drives the stream outputs directly.
module channel_skid_buf
  import cnn_accel_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;
  logic             pop;

  assign pop = (count_q != 2'd0) && ready;

  // Upstream credit guarantees a push never arrives while full without a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_data;
          else                 tail_q <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'(SKID_DEPTH)) begin
            head_q <= tail_q;
            tail_q <= push_data;
          end else begin
            head_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = head_q;
  assign out_valid = (count_q != 2'd0);
  assign occupancy = count_q;

endmodule

// File: rtl/channel_mem_reader.sv
// Streams one WIDTH x HEIGHT channel out of the feature-map memory in raster order.
// Define CHANNEL_MEM_READER_REPEAT_EN to add the Repeat port for multi-pass re-streaming.
module channel_mem_reader
  import cnn_accel_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIM_WIDTH  = 10
) (
  input  logic                  CHANNEL_MEM_READER_Clk,
  input  logic                  CHANNEL_MEM_READER_Reset_n,
  input  logic                  CHANNEL_MEM_READER_Start,
  input  logic [DIM_WIDTH-1:0]  CHANNEL_MEM_READER_Width,
  input  logic [DIM_WIDTH-1:0]  CHANNEL_MEM_READER_Height,
`ifdef CHANNEL_MEM_READER_REPEAT_EN
  input  logic [7:0]            CHANNEL_MEM_READER_Repeat,
`endif
  input  logic [DATA_WIDTH-1:0] CHANNEL_MEM_READER_Mem_Data,
  output logic                  CHANNEL_MEM_READER_Mem_Oe,
  output logic                  CHANNEL_MEM_READER_Mem_Rdinc,
  output logic                  CHANNEL_MEM_READER_Mem_Rptclr,
  output logic [DATA_WIDTH-1:0] CHANNEL_MEM_READER_Out_Data,
  output logic                  CHANNEL_MEM_READER_Out_Valid,
  input  logic                  CHANNEL_MEM_READER_Out_Ready,
  output logic                  CHANNEL_MEM_READER_Out_Eol,
  output logic                  CHANNEL_MEM_READER_Out_Eof,
  output logic                  CHANNEL_MEM_READER_Busy,
  output logic                  CHANNEL_MEM_READER_Done
);

  rd_state_e            state_q, state_n;
  logic [DIM_WIDTH-1:0] width_q, width_n, height_q, height_n;
  logic [DIM_WIDTH-1:0] col_q, col_n, row_q, row_n;
  logic                 mem_oe_q, mem_oe_n, rptclr_q, rptclr_n;
  logic                 busy_q, busy_n, done_q, done_n;
  logic                 eol_q, eol_n, eof_q, eof_n;
  logic [1:0]           occupancy;
  logic [2:0]           occ_after;
  logic                 out_valid, pop, issue, last_col, last_row;
  logic [DATA_WIDTH+1:0] skid_out;
`ifdef CHANNEL_MEM_READER_REPEAT_EN
  logic [7:0]           repeat_q, repeat_n, pass_q, pass_n;
`endif

  // Credit counts the word landing this edge and the one leaving, so a full-rate stream keeps issuing.
  assign pop       = out_valid & CHANNEL_MEM_READER_Out_Ready;
  assign occ_after = 3'(occupancy) + 3'(mem_oe_q) - 3'(pop);
  assign issue     = ((state_q == CLR) || (state_q == READ)) && (occ_after < 3'(SKID_DEPTH));
  assign last_col  = (col_q == width_q - DIM_WIDTH'(1));
  assign last_row  = (row_q == height_q - DIM_WIDTH'(1));

  always_ff @(posedge CHANNEL_MEM_READER_Clk or negedge CHANNEL_MEM_READER_Reset_n) begin
    if (!CHANNEL_MEM_READER_Reset_n) begin
      state_q  <= IDLE;
      width_q  <= '0;
      height_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      mem_oe_q <= 1'b0;
      rptclr_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
`ifdef CHANNEL_MEM_READER_REPEAT_EN
      repeat_q <= '0;
      pass_q   <= '0;
`endif
    end else begin
      state_q  <= state_n;
      width_q  <= width_n;
      height_q <= height_n;
      col_q    <= col_n;
      row_q    <= row_n;
      mem_oe_q <= mem_oe_n;
      rptclr_q <= rptclr_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      eol_q    <= eol_n;
      eof_q    <= eof_n;
`ifdef CHANNEL_MEM_READER_REPEAT_EN
      repeat_q <= repeat_n;
      pass_q   <= pass_n;
`endif
    end
  end

  always_comb begin
    state_n  = state_q;
    width_n  = width_q;
    height_n = height_q;
    col_n    = col_q;
    row_n    = row_q;
    mem_oe_n = 1'b0;
    rptclr_n = 1'b1;
    done_n   = 1'b0;
    eol_n    = 1'b0;
    eof_n    = 1'b0;
    busy_n   = done_q ? 1'b0 : busy_q;
`ifdef CHANNEL_MEM_READER_REPEAT_EN
    repeat_n = repeat_q;
    pass_n   = pass_q;
`endif

    // Row/frame markers are decided at issue time and ride with the fetch.
    if (issue) begin
      mem_oe_n = 1'b1;
      eol_n    = last_col;
      eof_n    = last_col && last_row;
      col_n    = last_col ? '0 : col_q + DIM_WIDTH'(1);
      if (last_col) row_n = last_row ? '0 : row_q + DIM_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (CHANNEL_MEM_READER_Start && !busy_q) begin
          width_n  = CHANNEL_MEM_READER_Width;
          height_n = CHANNEL_MEM_READER_Height;
          col_n    = '0;
          row_n    = '0;
          busy_n   = 1'b1;
`ifdef CHANNEL_MEM_READER_REPEAT_EN
          repeat_n = CHANNEL_MEM_READER_Repeat;
          pass_n   = '0;
`endif
          if ((CHANNEL_MEM_READER_Width == '0) || (CHANNEL_MEM_READER_Height == '0)) begin
            state_n = DONE;
          end else begin
            state_n  = CLR;
            rptclr_n = 1'b0;
          end
        end
      end
      CLR, READ: begin
        if (issue && last_col && last_row) state_n = DRAIN;
        else if (issue)                    state_n = READ;
      end
      DRAIN: begin
        if (occ_after == 3'd0) begin
`ifdef CHANNEL_MEM_READER_REPEAT_EN
          if (pass_q != repeat_q) begin
            pass_n   = pass_q + 8'd1;
            state_n  = CLR;
            rptclr_n = 1'b0;
          end else begin
            state_n = DONE;
          end
`else
          state_n = DONE;
`endif
        end
      end
      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  channel_skid_buf #(
    .WIDTH(DATA_WIDTH + 2)
  ) u_skid (
    .clk       (CHANNEL_MEM_READER_Clk),
    .rst_n     (CHANNEL_MEM_READER_Reset_n),
    .push      (mem_oe_q),
    .push_data ({eof_q, eol_q, CHANNEL_MEM_READER_Mem_Data}),
    .ready     (CHANNEL_MEM_READER_Out_Ready),
    .out_data  (skid_out),
    .out_valid (out_valid),
    .occupancy (occupancy)
  );

  assign {CHANNEL_MEM_READER_Out_Eof, CHANNEL_MEM_READER_Out_Eol, CHANNEL_MEM_READER_Out_Data} = skid_out;
  assign CHANNEL_MEM_READER_Out_Valid  = out_valid;
  assign CHANNEL_MEM_READER_Mem_Oe     = mem_oe_q;
  assign CHANNEL_MEM_READER_Mem_Rdinc  = mem_oe_q;
  assign CHANNEL_MEM_READER_Mem_Rptclr = rptclr_q;
  assign CHANNEL_MEM_READER_Busy       = busy_q;
  assign CHANNEL_MEM_READER_Done       = done_q;

endmodule

// File: tb/tb_channel_mem_reader.sv
// Directed bench for channel_mem_reader with a falling-edge memory model and stream monitor.
// Define CHANNEL_MEM_READER_REPEAT_EN to also cover multi-pass streaming.
module tb_channel_mem_reader;

  localparam int DW   = 16;
  localparam int DIMW = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [DIMW-1:0] width = '0;
  logic [DIMW-1:0] height = '0;
`ifdef CHANNEL_MEM_READER_REPEAT_EN
  logic [7:0]      rpt = 8'd0;
`endif
  logic [DW-1:0]   mem_data;
  logic            mem_oe, mem_rdinc, mem_rptclr;
  logic [DW-1:0]   out_data;
  logic            out_valid, out_eol, out_eof, busy, done;
  logic            out_ready = 1'b1;

  logic [DW-1:0]   mem [64];
  int              mem_ptr = 0;

  int edge_cnt = 0, start_edge = 0;
  int check_cnt = 0, pass_cnt = 0;
  int oe_cnt, clr_cnt, done_cnt, done_lat, busy_cnt, first_oe, first_x, last_x;
  int xfer_cnt, credit_errs, stall_errs;
  logic            held_valid;
  logic [17:0]     held_word;
  logic [17:0]     got_q[$];
  bit              ready_mode = 1'b0;
  logic [3:0]      rdy_pat = 4'b1001;

  channel_mem_reader #(
    .DATA_WIDTH(DW),
    .DIM_WIDTH (DIMW)
  ) dut (
    .CHANNEL_MEM_READER_Clk        (clk),
    .CHANNEL_MEM_READER_Reset_n    (rst_n),
    .CHANNEL_MEM_READER_Start      (start),
    .CHANNEL_MEM_READER_Width      (width),
    .CHANNEL_MEM_READER_Height     (height),
`ifdef CHANNEL_MEM_READER_REPEAT_EN
    .CHANNEL_MEM_READER_Repeat     (rpt),
`endif
    .CHANNEL_MEM_READER_Mem_Data   (mem_data),
    .CHANNEL_MEM_READER_Mem_Oe     (mem_oe),
    .CHANNEL_MEM_READER_Mem_Rdinc  (mem_rdinc),
    .CHANNEL_MEM_READER_Mem_Rptclr (mem_rptclr),
    .CHANNEL_MEM_READER_Out_Data   (out_data),
    .CHANNEL_MEM_READER_Out_Valid  (out_valid),
    .CHANNEL_MEM_READER_Out_Ready  (out_ready),
    .CHANNEL_MEM_READER_Out_Eol    (out_eol),
    .CHANNEL_MEM_READER_Out_Eof    (out_eof),
    .CHANNEL_MEM_READER_Busy       (busy),
    .CHANNEL_MEM_READER_Done       (done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  // Memory updates on the falling edge and drives zero whenever it is not enabled.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = DW'(i);
    mem_data = '0;
    forever begin
      @(negedge clk);
      if (!mem_rptclr) mem_ptr = 0;
      mem_data = mem_oe ? mem[mem_ptr] : '0;
      if (mem_rdinc) mem_ptr = (mem_ptr + 1) % 64;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = ready_mode ? rdy_pat[2'((edge_cnt - start_edge) % 4)] : 1'b1;
  end

  // Stream monitor; a fetch plus everything not yet transferred must never exceed two words.
  initial forever begin
    @(negedge clk);
    if (mem_oe) begin
      oe_cnt++;
      if (first_oe < 0) first_oe = edge_cnt - start_edge;
      if (oe_cnt - xfer_cnt > 2) credit_errs++;
    end
    if (!mem_rptclr) clr_cnt++;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_lat = edge_cnt - start_edge;
    end
    if (held_valid && (!out_valid || ({out_eof, out_eol, out_data} != held_word))) stall_errs++;
    held_valid = out_valid && !out_ready;
    held_word  = {out_eof, out_eol, out_data};
    if (out_valid && out_ready) begin
      got_q.push_back({out_eof, out_eol, out_data});
      if (first_x < 0) first_x = edge_cnt;
      last_x = edge_cnt;
      xfer_cnt++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks passed %0d of %0d", pass_cnt, check_cnt);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic clearMon();
    oe_cnt = 0; clr_cnt = 0; done_cnt = 0; done_lat = -1; busy_cnt = 0;
    first_oe = -1; first_x = -1; last_x = -1; xfer_cnt = 0;
    credit_errs = 0; stall_errs = 0; held_valid = 1'b0; held_word = '0;
    got_q.delete();
  endtask

  task automatic applyStimulus(input int w, input int h);
    @(posedge clk);
    #1;
    clearMon();
    start_edge = edge_cnt;
    width  = DIMW'(w);
    height = DIMW'(h);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget, input bit poke);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    else if (poke) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic checkFrame(input string tag, input int w, input int h, input int passes);
    int total, n, j;
    logic [17:0] exp;
    total = w * h * passes;
    checkOutput({tag, "_count"}, got_q.size(), total);
    n = (got_q.size() < total) ? got_q.size() : total;
    for (int i = 0; i < n; i++) begin
      j = i % (w * h);
      exp[15:0] = j[15:0];
      exp[16]   = ((j % w) == w - 1);
      exp[17]   = (j == w * h - 1);
      checkOutput($sformatf("%s_word%0d", tag, i), got_q[i], exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ctrl"}, {mem_oe, mem_rdinc, mem_rptclr, out_valid, out_eol, out_eof, busy, done},
                8'b0010_0000);
    checkOutput({tag, "_data"}, out_data, 0);
  endtask

  initial begin
    int n;
    clearMon();
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;

    // 4x3 frame at full rate
    applyStimulus(4, 3);
    waitDone("t1", 100, 1'b0);
    checkFrame("t1", 4, 3, 1);
    checkOutput("t1_first_oe", first_oe, 2);
    checkOutput("t1_consecutive", last_x - first_x, 11);
    checkOutput("t1_done_latency", done_lat, 16);
    checkOutput("t1_busy_cycles", busy_cnt, 16);
    checkOutput("t1_rptclr_cycles", clr_cnt, 1);
    checkOutput("t1_fetches", oe_cnt, 12);
    checkOutput("t1_credit", credit_errs, 0);

    // Same frame under 1,0,0,1 backpressure
    ready_mode = 1'b1;
    applyStimulus(4, 3);
    waitDone("t2", 200, 1'b0);
    ready_mode = 1'b0;
    checkFrame("t2", 4, 3, 1);
    checkOutput("t2_stall_stable", stall_errs, 0);
    checkOutput("t2_credit", credit_errs, 0);
    checkOutput("t2_fetches", oe_cnt, 12);
    checkOutput("t2_done_pulses", done_cnt, 1);

    // Zero-width frame
    applyStimulus(0, 5);
    waitDone("t3", 20, 1'b0);
    checkOutput("t3_done_latency", done_lat, 2);
    checkOutput("t3_busy_cycles", busy_cnt, 2);
    checkOutput("t3_rptclr_cycles", clr_cnt, 0);
    checkOutput("t3_fetches", oe_cnt, 0);
    checkOutput("t3_words", got_q.size(), 0);

    // Start mid-frame and again in the Done cycle
    applyStimulus(4, 3);
    repeat (5) @(posedge clk);
    #1;
    width = 10'd2; height = 10'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("t4", 100, 1'b1);
    checkFrame("t4", 4, 3, 1);
    checkOutput("t4_done_latency", done_lat, 16);
    checkOutput("t4_rptclr_cycles", clr_cnt, 1);
    checkOutput("t4_fetches", oe_cnt, 12);
    checkOutput("t4_busy_after", busy, 0);

    // Reset in the middle of a frame, then a fresh 2x2 frame
    applyStimulus(4, 3);
    n = 0;
    while (xfer_cnt < 5 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5_reached_five", (xfer_cnt >= 5), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("t5_async_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(2, 2);
    waitDone("t5", 50, 1'b0);
    checkFrame("t5", 2, 2, 1);
    checkOutput("t5_rptclr_cycles", clr_cnt, 1);

`ifdef CHANNEL_MEM_READER_REPEAT_EN
    // Three passes of a 2x2 channel
    rpt = 8'd2;
    applyStimulus(2, 2);
    waitDone("t6", 100, 1'b0);
    rpt = 8'd0;
    checkFrame("t6", 2, 2, 3);
    checkOutput("t6_rptclr_cycles", clr_cnt, 3);
    checkOutput("t6_done_pulses", done_cnt, 1);
    checkOutput("t6_fetches", oe_cnt, 12);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/channel_mem_reader.md
# channel_mem_reader

Read-side sequencer for the per-channel feature-map memory. On a start pulse it clears the memory read pointer, then streams a WIDTH×HEIGHT channel out of the memory in raster order. It drives the memory's output-enable, read-increment and read-pointer-clear controls, and presents each word on a valid/ready stream with end-of-row and end-of-frame markers. It sits between a channel memory and the convolution window/line-buffer logic that consumes pixels.

## Interface
Parameters:
- DATA_WIDTH, 16, pixel word width; equals the memory data width.
- DIM_WIDTH, 10, width of the row/column dimension inputs and counters.

Ports:
- CHANNEL_MEM_READER_Clk  in  1  single clock, rising edge. The memory itself updates on the falling edge of the same clock.
- CHANNEL_MEM_READER_Reset_n  in  1  asynchronous, active-low reset.
- CHANNEL_MEM_READER_Start  in  1  one-cycle start pulse; ignored while Busy=1.
- CHANNEL_MEM_READER_Width  in  DIM_WIDTH  pixels per row; latched on accepted Start.
- CHANNEL_MEM_READER_Height  in  DIM_WIDTH  rows per frame; latched on accepted Start.
- CHANNEL_MEM_READER_Repeat  in  8  frame pass count minus one (present only with the macro; see Configuration).
- CHANNEL_MEM_READER_Mem_Data  in  DATA_WIDTH  memory data output.
- CHANNEL_MEM_READER_Mem_Oe  out  1  memory output enable.
- CHANNEL_MEM_READER_Mem_Rdinc  out  1  memory read-pointer increment; always equals Mem_Oe.
- CHANNEL_MEM_READER_Mem_Rptclr  out  1  memory read-pointer clear, active-low.
- CHANNEL_MEM_READER_Out_Data  out  DATA_WIDTH  stream data.
- CHANNEL_MEM_READER_Out_Valid  out  1  stream valid.
- CHANNEL_MEM_READER_Out_Ready  in  1  stream ready; a transfer occurs when Valid&Ready at a rising edge.
- CHANNEL_MEM_READER_Out_Eol  out  1  the current word is the last of its row.
- CHANNEL_MEM_READER_Out_Eof  out  1  the current word is the last of its frame pass.
- CHANNEL_MEM_READER_Busy  out  1  high from the accepted Start until the Done cycle, inclusive.
- CHANNEL_MEM_READER_Done  out  1  one-cycle pulse after the final word transfers.

## Operation
- All outputs are registered.
- Reset values:
  - Mem_Oe = 0, Mem_Rdinc = 0, Mem_Rptclr = 1
  - Out_Valid = 0, Out_Data = 0, Eol = 0, Eof = 0
  - Busy = 0, Done = 0
  - State = IDLE; all counters 0.
- State machine:
  - IDLE: on Start, latch Width and Height, set Busy, and go to CLR. If Width==0 or Height==0, go directly to DONE with no memory access.
  - CLR: Mem_Rptclr=0 for exactly one cycle with Mem_Oe=0, then go to READ.
  - READ: issue one fetch per cycle (Mem_Oe=Mem_Rdinc=1) while credit is available. Credit means skid-buffer occupancy plus in-flight fetches is less than 2. Otherwise Mem_Oe=0. After the fetch of the last pixel is issued, go to DRAIN.
  - DRAIN: Mem_Oe=0; wait until the skid buffer is empty, then go to DONE, or back to CLR if passes remain.
  - DONE: Done=1 for one cycle, Busy drops on the following cycle, return to IDLE.
- Fetch path:
  - Mem_Oe is asserted at rising edge k.
  - The memory fetches on the following falling edge.
  - Mem_Data is captured into the skid buffer at rising edge k+1. Mem_Oe is still high during that capture because it is registered.
  - Mem_Data is never sampled in a cycle where Mem_Oe was 0; the memory forces it to zero then.
- Counters:
  - Column counts 0..Width-1; row counts 0..Height-1.
  - Eol and Eof are computed at issue time and travel with the data word through the skid buffer.
  - Eol=1 when col==Width-1. Eof=1 when, in addition, row==Height-1.
- The total fetch count equals Width×Height exactly. The memory pointer is not bounds-checked; Width×Height must not exceed the memory depth, and the pointer wraps silently if it does.
- Start while Busy=1 is ignored, including a Start in the DONE cycle.

## Timing
- Start to first Mem_Oe: 2 cycles (IDLE→CLR, then CLR→READ).
- Mem_Oe to Out_Valid: 1 cycle.
- With Ready held at 1, throughput is one word per cycle and a frame takes Width×Height + 4 cycles from Start to Done.
- Backpressure:
  - Out_Data, Eol and Eof stay stable while Valid=1 and Ready=0.
  - No word is dropped or duplicated.
  - At most 2 words are buffered or in flight.
- An asynchronous reset during any state returns all outputs to their reset values immediately. The partially read frame is abandoned, and the next Start re-clears the pointer.

## Configuration
- With CHANNEL_MEM_READER_REPEAT_EN defined:
  - The Repeat port exists and is latched on Start.
  - The block performs Repeat+1 full passes. Each pass is preceded by its own CLR cycle, so the same channel is re-streamed for successive filters.
  - Eof marks the end of each pass.
  - Done pulses once, after the last pass.
- Without the macro: the Repeat port is absent and there is exactly one pass.

## Structure
- Shared package cnn_accel_pkg holds:
  - the state encoding constants: IDLE, CLR, READ, DRAIN, DONE
  - the skid-buffer depth constant (2).
- One sub-module, channel_skid_buf: a 2-entry valid/ready buffer carrying {Eof, Eol, data}.
  - It reports occupancy to the credit logic.
  - All counting, the FSM and the memory controls remain in channel_mem_reader.

## Test plan
- Width=4, Height=3, Ready=1, memory preloaded with 0..11 → Out_Data 0..11 on consecutive cycles; Eol on 3, 7, 11; Eof on 11 only; Done 16 cycles after Start.
- Same frame, Ready toggling 1,0,0,1 repeatedly → identical data sequence with no loss or duplication; data stable while stalled; Mem_Oe never high while credit is 0.
- Width=0, Height=5 → no Mem_Oe and no Mem_Rptclr pulse; Done 2 cycles after Start; Busy high during both of those cycles.
- Start pulsed again mid-frame → ignored, and the frame completes unchanged.
- Reset asserted while in READ after 5 words → outputs return to reset values at once; a new Start with Width=2, Height=2 → Rptclr pulse, then data 0, 1, 2, 3.
- With CHANNEL_MEM_READER_REPEAT_EN, Repeat=2, Width=2, Height=2 → sequence 0, 1, 2, 3 emitted three times; three Eof markers; a Rptclr pulse before each pass; one Done pulse.
